// File: rtl/bus_master_arbiter_pkg.sv
// Shared definitions for the system-bus master arbiter: master indices,
// default master count and the arbiter FSM encoding.
package bus_arb_pkg;

  localparam int M_CPU_IF  = 0;
  localparam int M_CPU_DM  = 1;
  localparam int M_DMA     = 2;
  localparam int NUM_M_DEF = 3;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_OWN  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/bus_master_arbiter_if.sv
// Request/grant bundle between the bus requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface bus_master_arbiter_if
  import bus_arb_pkg::*;
#(
  parameter int NUM_M = NUM_M_DEF,
  parameter int ID_W  = $clog2(NUM_M)
);
  logic [NUM_M-1:0] req;
  logic [NUM_M-1:0] lock;
  logic             done;
  logic [NUM_M-1:0] grant;
  logic [ID_W-1:0]  grant_id;
  logic             grant_valid;
  logic             arb_timeout;

  modport master (
    output req, lock, done,
    input  grant, grant_id, grant_valid, arb_timeout
  );

  modport slave (
    input  req, lock, done,
    output grant, grant_id, grant_valid, arb_timeout
  );
endinterface

// File: rtl/bus_master_arbiter_rr_pick.sv
// Combinational round-robin selector: first set req bit scanning upward
// from rr_ptr+1, wrapping modulo NUM_M (works for non-power-of-two NUM_M).
module rr_pick
  import bus_arb_pkg::*;
#(
  parameter int NUM_M = NUM_M_DEF,
  parameter int ID_W  = $clog2(NUM_M)
) (
  input  logic [NUM_M-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  winner,
  output logic             found
);

  function automatic logic [ID_W-1:0] wrap_idx(input int base, input int off);
    int sum;
    sum = (base + off) % NUM_M;
    return sum[ID_W-1:0];
  endfunction

  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= NUM_M; i++) begin
      if (!found && req[wrap_idx(32'(rr_ptr), i)]) begin
        winner = wrap_idx(32'(rr_ptr), i);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_master_arbiter.sv
// Round-robin owner arbitration for the single system-bus master port.
// Optional bus-hang watchdog enabled by defining ARB_WATCHDOG_EN.
module bus_master_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_M   = NUM_M_DEF,
  parameter int ID_W    = $clog2(NUM_M),
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst,
  bus_master_arbiter_if.slave bus
);

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            timeout_q, timeout_d;
  logic            keep_bus;
  logic            wd_expire;

  rr_pick #(
    .NUM_M (NUM_M),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr_q),
    .winner (winner),
    .found  (found)
  );

  // A locked owner that still requests keeps the bus across the done boundary.
  assign keep_bus = bus.lock[owner_q] && bus.req[owner_q];

`ifdef ARB_WATCHDOG_EN
  localparam int               CNT_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] wd_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q == ARB_IDLE) || bus.done) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_q + CNT_W'(1);
    end
  end

  assign wd_expire = (state_q == ARB_OWN) && !bus.done && (wd_cnt_q == WD_LAST);
`else
  logic timeout_cfg_unused;

  assign wd_expire          = 1'b0;
  assign timeout_cfg_unused = (TIMEOUT != 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= ID_W'(NUM_M - 1);
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      timeout_q <= timeout_d;
    end
  end

  // On a watchdog expiry rr_ptr keeps the stalled owner so it drops to lowest priority.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    timeout_d = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          state_d  = ARB_OWN;
          owner_d  = winner;
          rr_ptr_d = winner;
        end
      end
      ARB_OWN: begin
        if (bus.done) begin
          if (!keep_bus) state_d = ARB_IDLE;
        end else if (wd_expire) begin
          state_d   = ARB_IDLE;
          timeout_d = 1'b1;
        end
      end
    endcase
  end

  always_comb begin
    bus.grant       = '0;
    bus.grant_id    = '0;
    bus.grant_valid = 1'b0;
    bus.arb_timeout = timeout_q;
    if (state_q == ARB_OWN) begin
      bus.grant[owner_q] = 1'b1;
      bus.grant_id       = owner_q;
      bus.grant_valid    = 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Self-checking bench for bus_master_arbiter: ownership model checked every
// cycle plus directed scenarios with literal expectations.
module tb_bus_master_arbiter;
  import bus_arb_pkg::*;

  localparam int NUM_M   = 3;
  localparam int ID_W    = 2;
  localparam int TIMEOUT = 8;
`ifdef ARB_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 1'b0;

  bus_master_arbiter_if #(.NUM_M(NUM_M), .ID_W(ID_W)) bus ();

  bus_master_arbiter #(
    .NUM_M   (NUM_M),
    .ID_W    (ID_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ownership model: who owns the bus, who won last, how long the owner has held it.
  int m_owner = -1;
  int m_last  = NUM_M - 1;
  int m_cnt   = 0;
  bit m_to    = 1'b0;
  int m_idx;

  always @(posedge clk) begin
    if (rst) begin
      m_owner = -1;
      m_last  = NUM_M - 1;
      m_cnt   = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= NUM_M; k++) begin
          m_idx = (m_last + k) % NUM_M;
          if (m_owner < 0 && bus.req[m_idx]) begin
            m_owner = m_idx;
            m_last  = m_idx;
            m_cnt   = 0;
          end
        end
      end else if (bus.done) begin
        m_cnt = 0;
        if (!(bus.lock[m_owner] && bus.req[m_owner])) m_owner = -1;
      end else if (WD && m_cnt == TIMEOUT - 1) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_cnt++;
      end
    end
  end

  always @(negedge clk) begin
    logic [NUM_M-1:0] exp_grant;
    if (cmp_en) begin
      exp_grant = '0;
      if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
      check("cyc_grant", int'(bus.grant), int'(exp_grant));
      check("cyc_grant_id", int'(bus.grant_id), (m_owner >= 0) ? m_owner : 0);
      check("cyc_grant_valid", int'(bus.grant_valid), (m_owner >= 0) ? 1 : 0);
      check("cyc_arb_timeout", int'(bus.arb_timeout), int'(m_to));
    end
  end

  int exp_seq [4] = '{0, 1, 2, 0};

  initial begin
    bus.req  = '0;
    bus.lock = '0;
    bus.done = 1'b0;
    rst      = 1'b1;
    step();
    step();
    check("rst_grant", int'(bus.grant), 0);
    check("rst_grant_id", int'(bus.grant_id), 0);
    check("rst_grant_valid", int'(bus.grant_valid), 0);
    check("rst_arb_timeout", int'(bus.arb_timeout), 0);
    rst    = 1'b0;
    cmp_en = 1'b1;

    // Single DMA request, one-cycle grant latency, release on done.
    bus.req = 3'b100;
    step();
    check("dma_grant", int'(bus.grant), 4);
    check("dma_grant_id", int'(bus.grant_id), M_DMA);
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = '0;
    check("dma_release", int'(bus.grant), 0);
    step();
    check("dma_idle", int'(bus.grant_valid), 0);

    // Round robin with all masters requesting, one idle cycle between grants.
    bus.req = 3'b111;
    step();
    for (int k = 0; k < 4; k++) begin
      check("rr_id", int'(bus.grant_id), exp_seq[k]);
      check("rr_valid", int'(bus.grant_valid), 1);
      step();
      check("rr_hold", int'(bus.grant_id), exp_seq[k]);
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check("rr_gap", int'(bus.grant_valid), 0);
      step();
    end
    bus.done = 1'b1;
    bus.req  = '0;
    step();
    bus.done = 1'b0;

    // DMA lock held across three done pulses while CPU IF waits.
    bus.req  = 3'b101;
    bus.lock = 3'b100;
    step();
    check("lock_first", int'(bus.grant), 4);
    for (int k = 0; k < 3; k++) begin
      bus.done = 1'b1;
      step();
      bus.done = 1'b0;
      check("lock_keep", int'(bus.grant), 4);
      check("lock_keep_valid", int'(bus.grant_valid), 1);
      step();
    end
    bus.lock = '0;
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    bus.req  = 3'b001;
    check("unlock_gap", int'(bus.grant_valid), 0);
    step();
    check("unlock_next", int'(bus.grant), 1);
    bus.done = 1'b1;
    bus.req  = '0;
    step();
    bus.done = 1'b0;

    // done in IDLE is ignored.
    step();
    bus.done = 1'b1;
    step();
    bus.done = 1'b0;
    check("idle_done_grant", int'(bus.grant), 0);
    check("idle_done_valid", int'(bus.grant_valid), 0);
    step();
    check("idle_done_stay", int'(bus.grant_valid), 0);

    // Reset during ownership drops the grant and restores master-0 priority.
    bus.req = 3'b010;
    step();
    check("pre_rst_id", int'(bus.grant_id), M_CPU_DM);
    rst = 1'b1;
    step();
    check("mid_rst_grant", int'(bus.grant), 0);
    rst     = 1'b0;
    bus.req = 3'b111;
    step();
    check("post_rst_first", int'(bus.grant), 1);
    check("post_rst_id", int'(bus.grant_id), M_CPU_IF);
    bus.done = 1'b1;
    bus.req  = '0;
    step();
    bus.done = 1'b0;
    step();

    // Stalled owner with no done.
    bus.req = 3'b010;
    step();
    check("stall_id", int'(bus.grant_id), M_CPU_DM);
`ifdef ARB_WATCHDOG_EN
    for (int c = 1; c < TIMEOUT; c++) begin
      step();
      check("wd_hold", int'(bus.grant_valid), 1);
      check("wd_quiet", int'(bus.arb_timeout), 0);
    end
    step();
    bus.req = 3'b011;
    check("wd_drop", int'(bus.grant_valid), 0);
    check("wd_pulse", int'(bus.arb_timeout), 1);
    step();
    check("wd_pulse_end", int'(bus.arb_timeout), 0);
    check("wd_next", int'(bus.grant), 1);
`else
    for (int c = 1; c < TIMEOUT + 4; c++) begin
      step();
      check("nowd_hold", int'(bus.grant_valid), 1);
      check("nowd_quiet", int'(bus.arb_timeout), 0);
    end
`endif
    bus.done = 1'b1;
    bus.req  = '0;
    step();
    bus.done = 1'b0;
    check("final_release", int'(bus.grant_valid), 0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_master_arbiter.md
Name: bus_master_arbiter

Overview:
- Shares the single system-bus master port between the CPU instruction fetch, the CPU data port and the DMA engine.
- Sits in front of the bus master interface. Each requester raises req and holds it until its transaction completes, signalled by the bus-side done pulse (last read beat or write response).
- Round-robin fairness. A lock input lets the DMA keep ownership across consecutive bursts of one transfer.

Parameters:
- NUM_M, 3, number of requesting masters (index 0 = CPU IF, 1 = CPU DM, 2 = DMA).
- ID_W, $clog2(NUM_M), width of grant_id.
- TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- req  in  NUM_M  per-master request; must be held until that master's transaction completes.
- lock  in  NUM_M  per-master lock; sampled on done to decide whether the owner keeps the bus.
- done  in  1  single-cycle pulse: current bus transaction finished.
- grant  out  NUM_M  one-hot grant, registered.
- grant_id  out  ID_W  binary index of the owner; valid only when grant_valid=1.
- grant_valid  out  1  bus owned by some master.
- arb_timeout  out  1  watchdog fired; one-cycle pulse (optional feature only, otherwise tied 0).

Behaviour:
- Reset (synchronous, active-high, clk rising edge) forces the following outputs and state:
  - grant=0, grant_id=0, grant_valid=0, arb_timeout=0.
  - FSM to IDLE.
  - rr_ptr (last winner) = NUM_M-1, so master 0 wins first.
  - Watchdog counter = 0.
- Reset mid-transaction drops the grant immediately; the requester must re-request.
- FSM has two states, IDLE and OWN.
- IDLE:
  - If req!=0, select the first requesting index scanning upward from rr_ptr+1, wrapping modulo NUM_M.
  - Next cycle: state=OWN, grant/grant_id/grant_valid set, rr_ptr=winner.
  - Latency from req to grant is 1 cycle. If req=0, stay in IDLE.
- OWN:
  - Outputs stay stable until done=1.
  - On done with lock[owner]=1 and req[owner]=1: remain in OWN with the same owner. No idle gap, rr_ptr unchanged.
  - On done otherwise: go to IDLE with grant cleared. This gives a one-cycle turnaround with grant_valid=0 before any new grant.
- done while in IDLE is ignored.
- req[owner] deasserted in OWN before done is a protocol violation. Grant is held until done regardless.
- Requests arriving during OWN are not preempted; they are considered at the next IDLE.
- Round-robin guarantee: with all req high and lock=0, grant order is 0,1,2,0,1,...
- Each grant is separated by IDLE cycles; no master waits more than NUM_M-1 other grants.
- req bits at indices >= NUM_M do not exist; the modulo wrap covers non-power-of-two NUM_M.

Optional Feature:
- Macro: ARB_WATCHDOG_EN.
- Defined: a counter clears on entering OWN and on every done, and increments each cycle in OWN.
  - When it reaches TIMEOUT-1 without done, the next cycle forces IDLE, clears grant and pulses arb_timeout=1 for one cycle.
  - rr_ptr keeps the stalled owner, so it loses priority to the others.
- Not defined: no counter, arb_timeout tied 0, OWN is held indefinitely until done.

Decomposition:
- Shared package bus_arb_pkg holds:
  - localparams for master indices (M_CPU_IF=0, M_CPU_DM=1, M_DMA=2).
  - Default NUM_M.
  - FSM enum arb_state_t {ARB_IDLE, ARB_OWN}.
- Sub-module rr_pick: a combinational round-robin selector (inputs req and rr_ptr; outputs winner index and found flag), reused by the interrupt controller later.
- Top level holds the FSM, the registers and the watchdog.

Test Plan:
- Reset then req=3'b100: cycle+1 gives grant=3'b100, grant_id=2. done pulse leads to grant=0 next cycle, then IDLE.
- req=3'b111 held, lock=0, done pulsed 2 cycles after each grant: grant_id sequence 0,1,2,0 with grant_valid=0 for exactly one cycle between grants.
- DMA holds lock=1 with req[2]=1 across 3 done pulses while req[0]=1: grant stays 3'b100 with no gap. Then lock=0 at the 4th done: IDLE for one cycle, then grant=3'b001.
- done pulse in IDLE with req=0: all outputs stay 0, and the FSM stays IDLE.
- rst asserted during OWN (owner 1): next cycle grant=0. After release with req=3'b111, the first grant is master 0.
- With ARB_WATCHDOG_EN and TIMEOUT=8: grant master 1 and never assert done. Grant drops after 8 cycles with arb_timeout=1 for exactly one cycle. With req=3'b011, the next grant goes to master 0.
